// File: rtl/ps_arb_pkg.sv
// Shared types and helpers for the PacketStream round-robin arbiter.
// The one-hot helper returns a wide vector; callers size-cast it down to SINKS bits.
package ps_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int MAX_SINKS = 64;

    function automatic logic [MAX_SINKS-1:0] onehot(input int idx, input int sinks);
        logic [MAX_SINKS-1:0] vec;
        vec = '0;
        if (idx >= 0 && idx < sinks && idx < MAX_SINKS) begin
            vec = MAX_SINKS'(1) << idx;
        end
        return vec;
    endfunction

endpackage

// File: rtl/ps_rr_pick.sv
// Combinational round-robin finder: first requester after last_ptr, wrapping,
// with last_ptr itself examined last.
module ps_rr_pick #(
    parameter  int SINKS = 2,
    localparam int SEL_W = $clog2(SINKS)
) (
    input  logic [SINKS-1:0] req,
    input  logic [SEL_W-1:0] last_ptr,
    output logic [SEL_W-1:0] pick,
    output logic             any_req
);

    logic [SEL_W-1:0] cand_idx [SINKS];
    logic [SINKS-1:0] rot_req;
    logic [SEL_W-1:0] chain    [SINKS+1];

    // Candidate gi is the index searched at position gi (offset gi+1 from last_ptr).
    generate
        for (genvar gi = 0; gi < SINKS; gi++) begin : g_rot
            assign cand_idx[gi] = SEL_W'((int'(last_ptr) + 1 + gi) % SINKS);
            assign rot_req[gi]  = req[cand_idx[gi]];
        end
    endgenerate

    // Priority chain built from the far end so the nearest candidate wins.
    assign chain[SINKS] = '0;
    generate
        for (genvar gi = 0; gi < SINKS; gi++) begin : g_chain
            assign chain[gi] = rot_req[gi] ? cand_idx[gi] : chain[gi+1];
        end
    endgenerate

    assign pick    = chain[0];
    assign any_req = |req;

endmodule

// File: rtl/ps_rr_arbiter.sv
// Packet-granular round-robin arbiter driving a PacketStream multiplexer select.
// A grant is held for up to QUOTA whole packets and never moves mid-packet.
module ps_rr_arbiter
    import ps_arb_pkg::*;
#(
    parameter  int SINKS = 2,
    parameter  int QUOTA = 1,
    localparam int SEL_W = $clog2(SINKS),
    localparam int CNT_W = $clog2(QUOTA + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SINKS-1:0] req,
    input  logic             pkt_val,
    input  logic             pkt_eop,
    input  logic             pkt_rdy,
    output logic [SEL_W-1:0] select,
    output logic [SINKS-1:0] grant,
    output logic             busy
);

    arb_state_e       state_reg;
    logic [SEL_W-1:0] select_reg;
    logic [SEL_W-1:0] last_ptr_reg;
    logic [SINKS-1:0] grant_reg;
    logic             busy_reg;
    logic             mid_pkt_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [SEL_W-1:0] pick;
    logic [SINKS-1:0] pick_oh;
    logic             any_req;
    logic             xfer;
    logic             eop_xfer;
    logic             req_sel;
    logic             cnt_inc_ok;
    logic             rearb;
    logic             take;
    logic             drop;

    ps_rr_pick #(
        .SINKS (SINKS)
    ) u_pick (
        .req      (req),
        .last_ptr (last_ptr_reg),
        .pick     (pick),
        .any_req  (any_req)
    );

    assign pick_oh    = SINKS'(onehot(int'(pick), SINKS));
    assign xfer       = pkt_val & pkt_rdy;
    assign eop_xfer   = xfer & pkt_eop;
    assign req_sel    = req[select_reg];
    assign cnt_inc_ok = (int'(cnt_reg) + 1) < QUOTA;

    // An EOP transfer takes precedence over a same-cycle withdrawal; a withdrawal
    // only counts while no packet is in flight and no beat moves this cycle.
    always_comb begin
        rearb = 1'b0;
        if (state_reg == LOCK) begin
            if (eop_xfer) begin
                rearb = !(cnt_inc_ok && req_sel);
            end else begin
                rearb = !xfer && !mid_pkt_reg && !req_sel;
            end
        end
    end

    assign take = any_req && ((state_reg == IDLE) || rearb);
    assign drop = rearb && !any_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            select_reg   <= '0;
            grant_reg    <= '0;
            busy_reg     <= 1'b0;
            cnt_reg      <= '0;
            mid_pkt_reg  <= 1'b0;
            last_ptr_reg <= SEL_W'(SINKS - 1);
        end else begin
            case (state_reg)
                IDLE: begin
                    // Stray pkt_val while idle is a protocol violation and is ignored.
                    if (take) begin
                        state_reg    <= LOCK;
                        select_reg   <= pick;
                        grant_reg    <= pick_oh;
                        last_ptr_reg <= pick;
                        cnt_reg      <= '0;
                        busy_reg     <= 1'b1;
                    end
                end
                LOCK: begin
                    if (eop_xfer) begin
                        mid_pkt_reg <= 1'b0;
                    end else if (xfer) begin
                        mid_pkt_reg <= 1'b1;
                    end
                    if (take) begin
                        select_reg   <= pick;
                        grant_reg    <= pick_oh;
                        last_ptr_reg <= pick;
                        cnt_reg      <= '0;
                    end else if (drop) begin
                        state_reg <= IDLE;
                        grant_reg <= '0;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else if (eop_xfer) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign select = select_reg;
    assign grant  = grant_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_ps_rr_arbiter.sv
// Bench for ps_rr_arbiter: two instances (QUOTA=1 and QUOTA=3) share stimulus;
// expected outputs are queued when inputs are driven and compared after the next edge.
module tb_ps_rr_arbiter;

    localparam int SINKS = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic [3:0] req     = 4'b0000;
    logic       pkt_val = 1'b0;
    logic       pkt_eop = 1'b0;
    logic       pkt_rdy = 1'b0;

    logic [1:0] sel1, sel3;
    logic [3:0] gnt1, gnt3;
    logic       busy1, busy3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         dut;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       busy;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    ps_rr_arbiter #(.SINKS(SINKS), .QUOTA(1)) dut_q1 (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .pkt_val (pkt_val),
        .pkt_eop (pkt_eop),
        .pkt_rdy (pkt_rdy),
        .select  (sel1),
        .grant   (gnt1),
        .busy    (busy1)
    );

    ps_rr_arbiter #(.SINKS(SINKS), .QUOTA(3)) dut_q3 (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .pkt_val (pkt_val),
        .pkt_eop (pkt_eop),
        .pkt_rdy (pkt_rdy),
        .select  (sel3),
        .grant   (gnt3),
        .busy    (busy3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic push(input int dut, input int s, input logic [3:0] g, input logic b,
                        input string tag);
        exp_t e;
        e.dut  = dut;
        e.sel  = 2'(s);
        e.gnt  = g;
        e.busy = b;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic push_both(input int s, input logic [3:0] g, input logic b, input string tag);
        push(1, s, g, b, tag);
        push(3, s, g, b, tag);
    endtask

    task automatic drive(input logic [3:0] r, input logic v, input logic e, input logic rd);
        @(negedge clk);
        req     = r;
        pkt_val = v;
        pkt_eop = e;
        pkt_rdy = rd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        req     = 4'b0000;
        pkt_val = 1'b0;
        pkt_eop = 1'b0;
        pkt_rdy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [3:0] oh(input int idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return v;
    endfunction

    // Scoreboard consumer: everything queued before an edge is checked just after it.
    always @(posedge clk) begin
        #1;
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.dut == 1) begin
                chk({mon_e.tag, "_q1_sel"},   32'(sel1),  32'(mon_e.sel));
                chk({mon_e.tag, "_q1_grant"}, 32'(gnt1),  32'(mon_e.gnt));
                chk({mon_e.tag, "_q1_busy"},  32'(busy1), 32'(mon_e.busy));
                $display("txn t=%0t q1 %s sel=%0d grant=%b busy=%b",
                         $time, mon_e.tag, sel1, gnt1, busy1);
            end else begin
                chk({mon_e.tag, "_q3_sel"},   32'(sel3),  32'(mon_e.sel));
                chk({mon_e.tag, "_q3_grant"}, 32'(gnt3),  32'(mon_e.gnt));
                chk({mon_e.tag, "_q3_busy"},  32'(busy3), 32'(mon_e.busy));
                $display("txn t=%0t q3 %s sel=%0d grant=%b busy=%b",
                         $time, mon_e.tag, sel3, gnt3, busy3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and first grant
        repeat (3) @(negedge clk);
        chk("in_reset_grant", 32'(gnt1), 32'd0);
        chk("in_reset_busy",  32'(busy3), 32'd0);
        reset = 1'b1;
        push_both(0, 4'b0000, 1'b0, "rst_idle");
        drive(4'b0110, 1'b0, 1'b0, 1'b0);
        push_both(1, 4'b0010, 1'b1, "first_grant");

        // Round-robin rotation, QUOTA=1, 3-beat packets
        do_reset();
        drive(4'b1111, 1'b0, 1'b0, 1'b0);
        push(1, 0, 4'b0001, 1'b1, "rr_g0");
        for (int p = 1; p <= 4; p++) begin
            for (int b = 0; b < 3; b++) begin
                drive(4'b1111, 1'b1, (b == 2), 1'b1);
                if (b == 2) push(1, p % 4, oh(p % 4), 1'b1, $sformatf("rr_eop%0d", p));
                else        push(1, (p - 1) % 4, oh((p - 1) % 4), 1'b1, $sformatf("rr_hold%0d", p));
            end
        end

        // Quota, QUOTA=3: packet 2 is single-beat
        do_reset();
        drive(4'b0011, 1'b0, 1'b0, 1'b0);
        push(3, 0, 4'b0001, 1'b1, "q_first");
        for (int p = 1; p <= 6; p++) begin
            int nb;
            int cur;
            int nxt;
            nb  = (p == 2) ? 1 : 2;
            cur = ((p - 1) / 3) % 2;
            nxt = (p / 3) % 2;
            for (int b = 0; b < nb; b++) begin
                drive(4'b0011, 1'b1, (b == nb - 1), 1'b1);
                if (b == nb - 1) push(3, nxt, oh(nxt), 1'b1, $sformatf("q_eop%0d", p));
                else             push(3, cur, oh(cur), 1'b1, $sformatf("q_hold%0d", p));
            end
        end

        // Mid-packet freeze: req[2] drops after beat 1 of 4, rdy stalls in between
        do_reset();
        drive(4'b0100, 1'b0, 1'b0, 1'b0);
        push_both(2, 4'b0100, 1'b1, "frz_grant");
        drive(4'b0101, 1'b1, 1'b0, 1'b1);
        push_both(2, 4'b0100, 1'b1, "frz_beat1");
        drive(4'b0001, 1'b1, 1'b0, 1'b1);
        push_both(2, 4'b0100, 1'b1, "frz_beat2");
        drive(4'b0001, 1'b1, 1'b0, 1'b0);
        push_both(2, 4'b0100, 1'b1, "frz_stall");
        drive(4'b0001, 1'b1, 1'b0, 1'b1);
        push_both(2, 4'b0100, 1'b1, "frz_beat3");
        drive(4'b0001, 1'b1, 1'b1, 1'b0);
        push_both(2, 4'b0100, 1'b1, "frz_eop_stall");
        drive(4'b0001, 1'b1, 1'b1, 1'b1);
        push_both(0, 4'b0001, 1'b1, "frz_eop");

        // Withdrawal before start, then idle, then stray pkt_val while idle
        do_reset();
        drive(4'b1010, 1'b0, 1'b0, 1'b0);
        push_both(1, 4'b0010, 1'b1, "wd_grant");
        drive(4'b1010, 1'b0, 1'b0, 1'b0);
        push_both(1, 4'b0010, 1'b1, "wd_hold");
        drive(4'b1000, 1'b0, 1'b0, 1'b0);
        push_both(3, 4'b1000, 1'b1, "wd_move");
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        push_both(3, 4'b0000, 1'b0, "wd_idle");
        drive(4'b0000, 1'b1, 1'b1, 1'b1);
        push_both(3, 4'b0000, 1'b0, "idle_stray_val");

        // Asynchronous reset during beat 2
        do_reset();
        drive(4'b0001, 1'b0, 1'b0, 1'b0);
        push_both(0, 4'b0001, 1'b1, "ar_grant");
        drive(4'b0001, 1'b1, 1'b0, 1'b1);
        push_both(0, 4'b0001, 1'b1, "ar_beat1");
        drive(4'b0001, 1'b1, 1'b0, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_async_grant_q1", 32'(gnt1),  32'd0);
        chk("ar_async_busy_q1",  32'(busy1), 32'd0);
        chk("ar_async_sel_q1",   32'(sel1),  32'd0);
        chk("ar_async_grant_q3", 32'(gnt3),  32'd0);
        chk("ar_async_busy_q3",  32'(busy3), 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        req     = 4'b1000;
        pkt_val = 1'b0;
        pkt_eop = 1'b0;
        pkt_rdy = 1'b0;
        push_both(3, 4'b1000, 1'b1, "ar_restart");

        @(posedge clk);
        #2;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
